// File: rtl/mem_responder_if.sv
// CPU memory port bundle: the initiator (master) drives requests, the responder (slave)
// returns read data, the completion pulse and the sticky error flag.
interface mem_responder_if;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata;
  logic        mem_done;
  logic        mem_error;

  modport master (
    output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_done, mem_error
  );

  modport slave (
    input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_done, mem_error
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: 64-bit-wide on-chip RAM with big-endian byte lanes, serving
// byte/wyde/tetra/octa accesses with optional wait states and a one-cycle done pulse.
module mem_responder #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [62:0]   addr_q;
  logic [1:0]    size_q;
  logic [63:0]   wdata_q;
  logic          read_q;

  logic [63:0]   ram [DEPTH];
  logic [63:0]   rd_word;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          first;
  logic [2:0]    off;
  logic [3:0]    nbytes;
  logic [2:0]    lane_lsb;
  logic [7:0]    be;
  logic [63:0]   wr_lanes;
  logic [63:0]   size_mask;
  logic [63:0]   ram_word;
  logic [63:0]   rd_aligned;

  // Lane geometry: the addressed field's lowest byte lane, counted from bit 0, is 8-off-size.
  always_comb begin
    idx      = addr_q[AW+2:3];
    in_range = addr_q[62:3] < 60'(DEPTH);
    first    = (state == ACCESS) && (cnt == 4'(WAIT_CYCLES));
    case (size_q)
      2'd0:    off = addr_q[2:0];
      2'd1:    off = {addr_q[2:1], 1'b0};
      2'd2:    off = {addr_q[2], 2'b00};
      default: off = 3'd0;
    endcase
    nbytes    = 4'd1 << size_q;
    lane_lsb  = 3'(4'd8 - 4'(off) - nbytes);
    be        = 8'((16'd1 << nbytes) - 16'd1) << lane_lsb;
    wr_lanes  = wdata_q << {lane_lsb, 3'b000};
    size_mask = (size_q == 2'd3) ? '1 : ((64'd1 << {nbytes, 3'b000}) - 64'd1);
    // With no wait states the word is consumed in the same cycle it is fetched.
    ram_word   = first ? ram[idx] : rd_word;
    rd_aligned = in_range ? ((ram_word >> {lane_lsb, 3'b000}) & size_mask) : '0;
  end

  // NOTE: the RAM array and its read register have no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (first && !reset) begin
      if (!read_q && in_range) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) ram[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
      rd_word <= ram[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      addr_q           <= '0;
      size_q           <= '0;
      wdata_q          <= '0;
      read_q           <= 1'b0;
      bus.mem_done     <= 1'b0;
      bus.mem_readdata <= '0;
      bus.mem_error    <= 1'b0;
    end else begin
      bus.mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            addr_q  <= bus.mem_address[62:0];
            size_q  <= bus.mem_datasize;
            wdata_q <= bus.mem_writedata;
            read_q  <= bus.mem_read;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= ACCESS;
            // Simultaneous read and write: the read wins, the write is dropped.
            if (bus.mem_read && bus.mem_write) bus.mem_error <= 1'b1;
          end
        end
        ACCESS: begin
          if (first && !in_range) bus.mem_error <= 1'b1;
          if (cnt == 4'd0) begin
            state        <= DONE;
            bus.mem_done <= 1'b1;
            if (read_q) bus.mem_readdata <= rd_aligned;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance without wait states, one with three.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0;
  logic reset3;

  mem_responder_if bus0 ();
  mem_responder_if bus3 ();

  mem_responder #(.DEPTH(4096), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset0), .bus(bus0));
  mem_responder #(.DEPTH(4096), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset3), .bus(bus3));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned cyc;
    logic        chk;
    logic [63:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus0.mem_done === 1'b1) begin
      if (q0.size() == 0) check("dut0_spurious_done", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        check("dut0_done_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk) check("dut0_readdata", bus0.mem_readdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus3.mem_done === 1'b1) begin
      if (q3.size() == 0) check("dut3_spurious_done", 64'd1, 64'd0);
      else begin
        e = q3.pop_front();
        check("dut3_done_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk) check("dut3_readdata", bus3.mem_readdata, e.data);
      end
    end
  end

  task automatic drive(input bit sel, input logic [63:0] a, input logic [1:0] s,
                       input logic r, input logic w, input logic [63:0] d);
    if (!sel) begin
      bus0.mem_address = a; bus0.mem_datasize = s; bus0.mem_read = r;
      bus0.mem_write = w;   bus0.mem_writedata = d;
    end else begin
      bus3.mem_address = a; bus3.mem_datasize = s; bus3.mem_read = r;
      bus3.mem_write = w;   bus3.mem_writedata = d;
    end
  endtask

  // One access: expectation queued at issue, request dropped in the cycle after done.
  task automatic access(input bit sel, input logic [63:0] a, input logic [1:0] s,
                        input logic r, input logic w, input logic [63:0] d,
                        input logic chk, input logic [63:0] exp);
    exp_t e;
    bit   seen;
    @(posedge clk); #1;
    drive(sel, a, s, r, w, d);
    e.cyc  = cyc + 2 + (sel ? 3 : 0);
    e.chk  = chk;
    e.data = exp;
    if (sel) q3.push_back(e);
    else     q0.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? bus3.mem_done : bus0.mem_done;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    drive(sel, '0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    exp_t        e;
    int unsigned s;

    drive(0, '0, '0, 1'b0, 1'b0, '0);
    drive(1, '0, '0, 1'b0, 1'b0, '0);
    reset0 = 1'b1;
    reset3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset0 = 1'b0;
    reset3 = 1'b0;
    @(negedge clk);
    check("rst_readdata", bus0.mem_readdata, 64'd0);
    check("rst_done",     64'(bus0.mem_done), 64'd0);
    check("rst_error",    64'(bus0.mem_error), 64'd0);

    // Octa write, octa read back, big-endian sub-word reads.
    access(0, 64'h8000000000000100, 2'd3, 1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0, '0);
    access(0, 64'h8000000000000100, 2'd3, 1'b1, 1'b0, '0, 1'b1, 64'h0123456789ABCDEF);
    access(0, 64'h101, 2'd0, 1'b1, 1'b0, '0, 1'b1, 64'h23);
    access(0, 64'h106, 2'd1, 1'b1, 1'b0, '0, 1'b1, 64'hCDEF);
    access(0, 64'h104, 2'd2, 1'b1, 1'b0, '0, 1'b1, 64'h89ABCDEF);
    access(0, 64'h107, 2'd0, 1'b1, 1'b0, '0, 1'b1, 64'hEF);
    check("no_error_yet", 64'(bus0.mem_error), 64'd0);

    // Byte write touches one lane only and leaves the read register alone.
    access(0, 64'h102, 2'd0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFF5A, 1'b0, '0);
    @(negedge clk);
    check("write_keeps_readdata", bus0.mem_readdata, 64'hEF);
    access(0, 64'h100, 2'd3, 1'b1, 1'b0, '0, 1'b1, 64'h01235A6789ABCDEF);
    access(0, 64'h106, 2'd2, 1'b1, 1'b0, '0, 1'b1, 64'h89ABCDEF);
    check("in_range_no_error", 64'(bus0.mem_error), 64'd0);

    // Out-of-range read: zero data, done still pulses, sticky error.
    access(0, 64'h8000, 2'd3, 1'b1, 1'b0, '0, 1'b1, 64'd0);
    @(negedge clk);
    check("oor_error", 64'(bus0.mem_error), 64'd1);

    @(posedge clk); #1 reset0 = 1'b1;
    @(posedge clk); #1 reset0 = 1'b0;
    @(negedge clk);
    check("rst2_error",    64'(bus0.mem_error), 64'd0);
    check("rst2_readdata", bus0.mem_readdata, 64'd0);

    // Contention: read served, write dropped, error flagged.
    access(0, 64'h100, 2'd3, 1'b1, 1'b1, 64'd0, 1'b1, 64'h01235A6789ABCDEF);
    @(negedge clk);
    check("contention_error", 64'(bus0.mem_error), 64'd1);
    // Out-of-range write must not alias onto word 0x100.
    access(0, 64'h8100, 2'd3, 1'b0, 1'b1, 64'hDEADBEEFDEADBEEF, 1'b0, '0);
    access(0, 64'h100, 2'd3, 1'b1, 1'b0, '0, 1'b1, 64'h01235A6789ABCDEF);

    // Wait-state instance.
    access(1, 64'h200, 2'd3, 1'b0, 1'b1, 64'h1122334455667788, 1'b0, '0);
    access(1, 64'h204, 2'd1, 1'b1, 1'b0, '0, 1'b1, 64'h5566);

    // Read held for 20 cycles: completions every 6 cycles.
    @(posedge clk); #1;
    drive(1, 64'h200, 2'd3, 1'b1, 1'b0, '0);
    s = cyc;
    for (int k = 0; k < 4; k++) begin
      e.cyc  = s + 5 + 6 * k;
      e.chk  = 1'b1;
      e.data = 64'h1122334455667788;
      q3.push_back(e);
    end
    repeat (20) @(posedge clk);
    #1;
    drive(1, '0, '0, 1'b0, 1'b0, '0);
    repeat (8) @(posedge clk);

    // Reset in cycle 2 of a read: no done, read data cleared.
    @(posedge clk); #1;
    drive(1, 64'h200, 2'd3, 1'b1, 1'b0, '0);
    @(posedge clk);
    @(posedge clk); #1;
    reset3 = 1'b1;
    drive(1, '0, '0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    reset3 = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid_readdata", bus3.mem_readdata, 64'd0);
    access(1, 64'h200, 2'd3, 1'b1, 1'b0, '0, 1'b1, 64'h1122334455667788);

    repeat (4) @(posedge clk);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q3_drained", 64'(q3.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
